// File: rtl/gray_code_converter_arbiter.sv
// rtl/gray_code_converter_arbiter.sv - round-robin arbiter sharing one binary/Gray conversion datapath
// Four requesters; binary->Gray in one cycle, Gray->binary bit-serial MSB first.
module gray_code_converter_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    Clock_In,
  input  logic                    Reset_In,
  input  logic                    Enable_In,
  input  logic [3:0]              Req_Valid_In,
  input  logic [3:0]              Req_Mode_In,
  input  logic [4*DATA_WIDTH-1:0] Req_Data_In,
  output logic [3:0]              Req_Ready_Out,
  output logic                    Result_Valid_Out,
  input  logic                    Result_Ready_In,
  output logic [DATA_WIDTH-1:0]   Result_Data_Out,
  output logic [1:0]              Result_Id_Out,
  output logic                    Result_Mode_Out,
  output logic                    Busy_Out
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, CONV, OUT} state_t;

  state_t                  state, state_next;
  logic [1:0]              last_grant, grant_id, work_id;
  logic                    grant_found, work_mode, prev_bit, serial_bit, conv_done;
  logic [DATA_WIDTH-1:0]   work_data, acc, acc_next;
  logic [CW-1:0]           bit_cnt;

  // Search starts one past the last winner; reset also masks the grant immediately.
  always_comb begin
    grant_found   = 1'b0;
    grant_id      = last_grant;
    Req_Ready_Out = 4'b0000;
    if (state == IDLE && Enable_In && !Reset_In) begin
      for (int k = 1; k <= 4; k++) begin
        if (!grant_found && Req_Valid_In[2'(int'(last_grant) + k)]) begin
          grant_found = 1'b1;
          grant_id    = 2'(int'(last_grant) + k);
        end
      end
    end
    if (grant_found) Req_Ready_Out = 4'b0001 << grant_id;
  end

  always_comb begin
    serial_bit        = prev_bit ^ work_data[bit_cnt];
    acc_next          = acc;
    acc_next[bit_cnt] = serial_bit;
    conv_done         = work_mode ? (bit_cnt == '0) : 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_found) state_next = CONV;
      CONV:    if (conv_done) state_next = OUT;
      OUT:     if (Result_Ready_In) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign Result_Valid_Out = (state == OUT);
  assign Busy_Out         = (state != IDLE);

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state           <= IDLE;
      last_grant      <= 2'd3;
      work_data       <= '0;
      work_mode       <= 1'b0;
      work_id         <= 2'd0;
      acc             <= '0;
      prev_bit        <= 1'b0;
      bit_cnt         <= '0;
      Result_Data_Out <= '0;
      Result_Id_Out   <= 2'd0;
      Result_Mode_Out <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_found) begin
        work_data  <= Req_Data_In[grant_id*DATA_WIDTH +: DATA_WIDTH];
        work_mode  <= Req_Mode_In[grant_id];
        work_id    <= grant_id;
        last_grant <= grant_id;
        bit_cnt    <= CW'(DATA_WIDTH - 1);
        prev_bit   <= 1'b0;
        acc        <= '0;
      end
      if (state == CONV) begin
        if (work_mode) begin
          acc      <= acc_next;
          prev_bit <= serial_bit;
          if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
        end
        // Result registers load only on the CONV->OUT edge so partial bits stay hidden.
        if (conv_done) begin
          Result_Data_Out <= work_mode ? acc_next : (work_data ^ (work_data >> 1));
          Result_Id_Out   <= work_id;
          Result_Mode_Out <= work_mode;
        end
      end
    end
  end

endmodule

// File: tb/tb_gray_code_converter_arbiter.sv
// tb/tb_gray_code_converter_arbiter.sv - scoreboard bench for gray_code_converter_arbiter
module tb_gray_code_converter_arbiter;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic [3:0]     req_valid = '0;
  logic [3:0]     req_mode = '0;
  logic [4*W-1:0] req_data = '0;
  logic [3:0]     req_ready;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [W-1:0]   res_data;
  logic [1:0]     res_id;
  logic           res_mode;
  logic           busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0]   id;
    logic         mode;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   grant_cyc[$];
  int   result_log[$];
  bit   model_busy = 1'b0;
  int   model_last = 3;
  int   rise_cyc = 0;

  gray_code_converter_arbiter #(.DATA_WIDTH(W)) dut (
    .Clock_In(clk), .Reset_In(rst), .Enable_In(en),
    .Req_Valid_In(req_valid), .Req_Mode_In(req_mode), .Req_Data_In(req_data),
    .Req_Ready_Out(req_ready), .Result_Valid_Out(res_valid), .Result_Ready_In(res_ready),
    .Result_Data_Out(res_data), .Result_Id_Out(res_id), .Result_Mode_Out(res_mode),
    .Busy_Out(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the parity of all Gray bits at or above it.
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int i = 0; i < W; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor and scoreboard: reference grant model pushes, result side pops.
  always @(negedge clk) begin
    logic [3:0] exp_ready;
    int         win;
    exp_t       e;
    if (rst) begin
      sb.delete();
      model_busy = 1'b0;
      model_last = 3;
    end else begin
      exp_ready = 4'b0000;
      win = -1;
      if (!model_busy && en) begin
        for (int k = 1; k <= 4; k++) begin
          if (win < 0 && req_valid[(model_last + k) % 4]) win = (model_last + k) % 4;
        end
        if (win >= 0) exp_ready = 4'(1 << win);
      end
      chk("grant", req_ready, exp_ready);
      chk("busy", busy, model_busy);
      chk("result_valid", res_valid, model_busy && cyc >= rise_cyc);
      if (res_valid && sb.size() > 0) begin
        chk("result_data", res_data, sb[0].data);
        chk("result_id", res_id, sb[0].id);
        chk("result_mode", res_mode, sb[0].mode);
      end
      if (win >= 0) begin
        e.id   = 2'(win);
        e.mode = req_mode[win];
        e.data = e.mode ? g2b(req_data[win*W +: W]) : b2g(req_data[win*W +: W]);
        sb.push_back(e);
        model_busy = 1'b1;
        model_last = win;
        rise_cyc = cyc + (e.mode ? W + 1 : 2);
        grant_log.push_back(win);
        grant_cyc.push_back(cyc);
      end else if (model_busy && res_valid && res_ready) begin
        if (sb.size() > 0) void'(sb.pop_front());
        result_log.push_back(int'(res_data));
        model_busy = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    step();
    rst = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic put_req(input int id, input logic mode, input logic [W-1:0] data);
    req_valid[id] = 1'b1;
    req_mode[id] = mode;
    req_data[id*W +: W] = data;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!res_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    #1;
    chk("reset_ready", req_ready, 0);
    chk("reset_valid", res_valid, 0);
    chk("reset_data", res_data, 0);
    chk("reset_id", res_id, 0);
    chk("reset_mode", res_mode, 0);
    chk("reset_busy", busy, 0);
    step();
    rst = 1'b0;
    en = 1'b1;
    res_ready = 1'b1;

    // Requester 0, binary->Gray of 0x5A.
    step();
    put_req(0, 1'b0, 8'h5A);
    @(negedge clk);
    chk("t1_grant", req_ready, 4'b0001);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("t1_valid_c1", res_valid, 0);
    @(negedge clk);
    chk("t1_valid_c2", res_valid, 1);
    chk("t1_data", res_data, 8'h77);
    chk("t1_id", res_id, 0);
    chk("t1_mode", res_mode, 0);
    @(negedge clk);
    chk("t1_valid_c3", res_valid, 0);

    // Requester 2, Gray->binary of 0x77.
    step();
    put_req(2, 1'b1, 8'h77);
    @(negedge clk);
    chk("t2_grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    @(negedge clk);
    n = 1;
    while (!res_valid && n < 40) begin
      chk("t2_busy", busy, 1);
      @(negedge clk);
      n++;
    end
    chk("t2_latency", n, W + 1);
    chk("t2_data", res_data, 8'h5A);
    chk("t2_id", res_id, 2);
    chk("t2_mode", res_mode, 1);

    // All four requesters held valid.
    reset_dut();
    res_ready = 1'b1;
    grant_log.delete();
    grant_cyc.delete();
    result_log.delete();
    put_req(0, 1'b0, 8'h01);
    put_req(1, 1'b0, 8'h02);
    put_req(2, 1'b0, 8'h04);
    put_req(3, 1'b0, 8'h80);
    repeat (14) step();
    req_valid = '0;
    repeat (4) step();
    chk("t3_grant_count", grant_log.size() >= 5, 1);
    if (grant_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("t3_grant_order", grant_log[i], i % 4);
      for (int i = 1; i < 5; i++) chk("t3_grant_spacing", grant_cyc[i] - grant_cyc[i-1], 3);
    end
    chk("t3_result_count", result_log.size() >= 4, 1);
    if (result_log.size() >= 4) begin
      chk("t3_res0", result_log[0], 8'h01);
      chk("t3_res1", result_log[1], 8'h03);
      chk("t3_res2", result_log[2], 8'h06);
      chk("t3_res3", result_log[3], 8'hC0);
    end

    // Consumer back-pressure for 5 cycles.
    res_ready = 1'b0;
    put_req(1, 1'b0, 8'h5A);
    @(negedge clk);
    step();
    req_valid = '0;
    wait_valid("t4", n);
    step();
    req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_data", res_data, 8'h77);
      chk("t4_hold_valid", res_valid, 1);
      chk("t4_hold_ready", req_ready, 4'b0000);
      chk("t4_hold_busy", busy, 1);
      step();
    end
    req_valid = '0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("t4_valid_before_edge", res_valid, 1);
    @(negedge clk);
    chk("t4_idle_after_edge", busy, 0);

    // Enable low blocks every grant.
    step();
    en = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t5_no_grant", req_ready, 4'b0000);
    end
    step();
    req_valid = '0;
    en = 1'b1;

    // Enable dropped in CONV cycle 3 of a Gray->binary job.
    step();
    put_req(1, 1'b1, 8'hC3);
    @(negedge clk);
    chk("t5_grant", req_ready, 4'b0010);
    step();
    req_valid = '0;
    step();
    step();
    en = 1'b0;
    req_valid = 4'b1111;
    wait_valid("t5", n);
    chk("t5_data", res_data, g2b(8'hC3));
    chk("t5_id", res_id, 1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("t5_no_regrant", req_ready, 4'b0000);
    end
    step();
    req_valid = '0;
    en = 1'b1;

    // Reset in CONV cycle 4 of a Gray->binary job from requester 3.
    reset_dut();
    step();
    put_req(3, 1'b1, 8'h9E);
    @(negedge clk);
    chk("t6_grant", req_ready, 4'b1000);
    step();
    req_valid = '0;
    step();
    step();
    step();
    rst = 1'b1;
    req_valid = 4'b1010;
    #1;
    chk("t6_rst_ready", req_ready, 0);
    chk("t6_rst_valid", res_valid, 0);
    chk("t6_rst_data", res_data, 0);
    chk("t6_rst_id", res_id, 0);
    chk("t6_rst_mode", res_mode, 0);
    chk("t6_rst_busy", busy, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_first_grant", req_ready, 4'b0010);
    step();
    req_valid = '0;
    repeat (15) step();

    // Randomised traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_mode = 4'($urandom_range(0, 15));
      req_data = {$urandom(), $urandom()};
      res_ready = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 7) != 0);
      step();
    end
    req_valid = '0;
    res_ready = 1'b1;
    en = 1'b1;
    repeat (20) step();
    chk("drain_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
